// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath constants and types
package cpu_pkg;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/dff_vec.sv
// rtl/dff_vec.sv - WIDTH-bit enable register with async active-low reset to RVAL
module dff_vec #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] RVAL  = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= RVAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 2-read/1-write register file with optional zero word and write bypass
module reg_file_2r1w
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = DATA_W,
  parameter int               DEPTH    = NUM_REGS,
  parameter int               AW       = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RVAL     = {WIDTH{1'b0}},
  parameter bit               ZERO_REG = 1'b1,
  parameter bit               BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] w_mem [DEPTH];
  logic             w_waddr_ok;
  logic             w_wr_live;

  // A write is live only for an in-range, storable word while out of reset.
  assign w_waddr_ok = (int'(waddr) < DEPTH) && !(ZERO_REG && (waddr == '0));
  assign w_wr_live  = reset && we && w_waddr_ok;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_word
      if (ZERO_REG && (i == 0)) begin : g_zero
        assign w_mem[i] = '0;
      end else begin : g_store
        logic w_en;
        assign w_en = we && (waddr == AW'(i));
        dff_vec #(
          .WIDTH (WIDTH),
          .RVAL  (RVAL)
        ) u_word (
          .clk   (clk),
          .reset (reset),
          .en    (w_en),
          .d     (wdata),
          .q     (w_mem[i])
        );
      end
    end
  endgenerate

  always_comb begin
    rdata_a = '0;
    if (int'(raddr_a) < DEPTH) rdata_a = w_mem[raddr_a];
    if (BYPASS && w_wr_live && (raddr_a == waddr)) rdata_a = wdata;
    if (ZERO_REG && (raddr_a == '0)) rdata_a = '0;
  end

  always_comb begin
    rdata_b = '0;
    if (int'(raddr_b) < DEPTH) rdata_b = w_mem[raddr_b];
    if (BYPASS && w_wr_live && (raddr_b == waddr)) rdata_b = wdata;
    if (ZERO_REG && (raddr_b == '0)) rdata_b = '0;
  end

  a_we_known : assert property (@(posedge clk) disable iff (!reset) !$isunknown(we));

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file with two read ports and one write port, built for the CPU datapath.
- Generalises the single-bit enable/reset flip-flop to DEPTH words of WIDTH bits.
- Each word has a common reset value.
- Adds optional hardwired-zero register 0 and optional same-cycle write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- WIDTH, 32, bits per register word (>=1).
- DEPTH, 32, number of words (>=2; need not be a power of two).
- AW, $clog2(DEPTH), address width. Derived; not overridden.
- RVAL, {WIDTH{1'b0}}, value loaded into every word on reset.
- ZERO_REG, 1:
  - 1: word 0 always reads 0 and ignores writes.
  - 0: word 0 is an ordinary register.
- BYPASS, 1:
  - 1: a read of the address being written this cycle returns wdata.
  - 0: a read returns the stored value.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- raddr_a  in  AW  read port A address
- rdata_a  out  WIDTH  read port A data
- raddr_b  in  AW  read port B address
- rdata_b  out  WIDTH  read port B data

Behaviour:
- Reset:
  - reset low immediately forces every stored word to RVAL, with no clock required.
  - Words are held at RVAL while reset is low; writes are ignored.
  - Outputs during reset are RVAL, or 0 for word 0 when ZERO_REG=1.
  - Release is synchronous to nothing. The first write takes effect on the first rising edge with reset high.
- Write:
  - On rising clk with reset high and we=1, mem[waddr] <= wdata.
  - On rising clk with we=0, all words hold.
  - Write latency: stored value is visible through the non-bypass path from the cycle after the edge.
- Read:
  - Combinational (asynchronous) from raddr_x.
  - Zero clock latency; the two ports are fully independent.
  - Both ports may read the same address.
- Bypass (BYPASS=1):
  - Applies when reset high, we=1, raddr_x==waddr and the address is writable.
  - rdata_x = wdata in the same cycle, combinationally.
  - When BYPASS=0, rdata_x shows the old value until after the edge.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 regardless of RVAL or bypass.
  - No storage is inferred for word 0.
- Out-of-range addresses (address >= DEPTH, non-power-of-two DEPTH):
  - Writes are ignored; no word is modified and nothing aliases.
  - Reads return 0; bypass never applies.
- Simultaneous events:
  - Reset asserted on the same edge as a write: reset wins and the word stays at RVAL.
  - Write and read to the same address: governed by BYPASS as above.
- X handling: we=X with reset high is a simulation assertion error; no silent corruption of other words is permitted.

Decomposition:
- Shared package (cpu_pkg) provides:
  - default data width constant DATA_W=32
  - register count NUM_REGS=32
  - typedef word_t logic [DATA_W-1:0]
- Sub-module dff_vec:
  - WIDTH-bit enable register with asynchronous active-low reset to a parameter value; the vector successor of the single-bit flip-flop.
  - Instantiated once per storable word via generate.
  - Enable = we & (waddr==i) & valid(i).
- Read muxes, bypass compare and the zero override live in reg_file_2r1w itself.

Test Plan:
- Reset behaviour. Stimulus: WIDTH=32, DEPTH=32, RVAL=32'hDEAD_BEEF; drive reset low mid-cycle with no clock edge. Required response: rdata_a at raddr_a=5 reads 32'hDEAD_BEEF immediately, and reads 0 at address 0.
- Write then read. Stimulus: write 32'h1234_5678 to addr 7; we=0 next cycle. Required response: raddr_a=7 and raddr_b=7 both return 32'h1234_5678. Address 8 still returns RVAL.
- Same-cycle bypass. Stimulus: we=1, waddr=3, wdata=32'hA5A5_A5A5, raddr_a=3, old value 0.
  - BYPASS=1: rdata_a=32'hA5A5_A5A5 before the edge.
  - BYPASS=0: rdata_a=0 before the edge and 32'hA5A5_A5A5 after it.
- Zero register. Stimulus: with ZERO_REG=1, write 32'hFFFF_FFFF to addr 0 with raddr_b=0. Required response: rdata_b=0 in the same cycle and on the next cycle.
  - Repeat with ZERO_REG=0: rdata_b=32'hFFFF_FFFF after the edge.
- Out-of-range address. Stimulus: DEPTH=20, AW=5; write 32'h55 to addr 25. Required response: reads of 25 return 0, and words 9 and 5 are unchanged (no aliasing).
- Reset mid-operation. Stimulus: reset low on the same edge as a write of 32'h77 to addr 4, then release reset. Required response: addr 4 reads RVAL. The next write of 32'h77 is stored on the first edge after release.
